// File: rtl/fifo_stream_reader.sv
// Read-side master for a 1-cycle-latency sync FIFO: pops words and presents them
// as a gap-free valid/ready stream through a 2-entry prefetch buffer.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] slot1;
  logic                  pop;
  logic [2:0]            credit;

  assign pop = m_valid & m_ready;

  // Words held or arriving after this cycle's pop; a new read needs room for one more.
  always_comb begin
    credit     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd_en = !rst && !fifo_empty && (credit <= 3'd1);
  end

  // m_data doubles as the head slot, so it is registered and holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= EMPTY;
      inflight <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      slot1    <= '0;
      xfer_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) xfer_cnt <= xfer_cnt + 1'b1;
      assert (!(occ == TWO && inflight));
      case (occ)
        EMPTY: begin
          if (inflight) begin
            occ     <= ONE;
            m_data  <= fifo_data;
            m_valid <= 1'b1;
          end
        end
        ONE: begin
          if (inflight && !pop) begin
            occ   <= TWO;
            slot1 <= fifo_data;
          end else if (pop && !inflight) begin
            occ     <= EMPTY;
            m_valid <= 1'b0;
          end else if (inflight && pop) begin
            m_data <= fifo_data;
          end
        end
        TWO: begin
          if (pop) begin
            occ    <= ONE;
            m_data <= slot1;
          end
        end
        default: begin
          occ     <= EMPTY;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
